// File: rtl/sinegen_sequencer_if.sv
// sinegen_sequencer_if: config handshake, run control and ROM address/strobe bundle (SINEGEN_SWEEP_EN adds cfg_step)
interface sinegen_sequencer_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int PHASE_WIDTH   = 16
);
    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [PHASE_WIDTH-1:0]   cfg_incr;
    logic [ADDRESS_WIDTH-1:0] cfg_offset;
    logic [15:0]              cfg_count;
`ifdef SINEGEN_SWEEP_EN
    logic [PHASE_WIDTH-1:0]   cfg_step;
`endif
    logic                     start;
    logic                     stop;
    logic [ADDRESS_WIDTH-1:0] addr1;
    logic [ADDRESS_WIDTH-1:0] addr2;
    logic                     dout_valid;
    logic                     busy;
    logic                     done;

    modport master (
`ifdef SINEGEN_SWEEP_EN
        output cfg_step,
`endif
        output cfg_valid, cfg_incr, cfg_offset, cfg_count, start, stop,
        input  cfg_ready, addr1, addr2, dout_valid, busy, done
    );

    modport slave (
`ifdef SINEGEN_SWEEP_EN
        input  cfg_step,
`endif
        input  cfg_valid, cfg_incr, cfg_offset, cfg_count, start, stop,
        output cfg_ready, addr1, addr2, dout_valid, busy, done
    );
endinterface

// File: rtl/sinegen_sequencer.sv
// sinegen_sequencer: phase-accumulator address sequencer for a dual-port sine ROM (SINEGEN_SWEEP_EN enables increment sweep)
module sinegen_sequencer #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int PHASE_WIDTH   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    sinegen_sequencer_if.slave bus
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int PW = PHASE_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d, incr_q, incr_d, einc_q, einc_d, psum;
    logic [AW-1:0]   offset_q, offset_d, addr1_q, addr1_d, addr2_q, addr2_d;
    logic [15:0]     count_q, count_d, cnt_q, cnt_d;
    logic            run_q, xfer, last;
`ifdef SINEGEN_SWEEP_EN
    logic [PW-1:0]   step_q, step_d;
    logic [PW:0]     swept;
    logic            carry;
`endif

    // Config latch, phase/count advance, state transitions and next addresses
    always_comb begin
        xfer     = bus.cfg_valid && state_q == IDLE;
        incr_d   = xfer ? bus.cfg_incr   : incr_q;
        offset_d = xfer ? bus.cfg_offset : offset_q;
        count_d  = xfer ? bus.cfg_count  : count_q;
`ifdef SINEGEN_SWEEP_EN
        step_d   = xfer ? bus.cfg_step   : step_q;
        {carry, psum} = {1'b0, phase_q} + {1'b0, einc_q};
        swept    = {1'b0, einc_q} + {1'b0, step_q};
`else
        psum     = phase_q + einc_q;
`endif
        last     = (count_q != 16'd0 && cnt_q + 16'd1 == count_q) || bus.stop;
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        einc_d   = einc_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                phase_d = '0;
                cnt_d   = '0;
                einc_d  = incr_d;
            end
            RUN: begin
                phase_d = psum;
                cnt_d   = cnt_q + 16'd1;
                state_d = last ? DRAIN : RUN;
`ifdef SINEGEN_SWEEP_EN
                if (carry) einc_d = swept[PW] ? '1 : swept[PW-1:0];
`endif
            end
            default: state_d = IDLE;
        endcase
        addr1_d = state_d == RUN ? phase_d[PW-1 -: AW]            : addr1_q;
        addr2_d = state_d == RUN ? phase_d[PW-1 -: AW] + offset_d : addr2_q;
    end

    // State and datapath registers; run_q delays RUN by the ROM read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            incr_q   <= '0;
            einc_q   <= '0;
            offset_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            run_q    <= 1'b0;
`ifdef SINEGEN_SWEEP_EN
            step_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            incr_q   <= incr_d;
            einc_q   <= einc_d;
            offset_q <= offset_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            run_q    <= state_q == RUN;
`ifdef SINEGEN_SWEEP_EN
            step_q   <= step_d;
`endif
        end
    end

    assign bus.cfg_ready  = state_q == IDLE;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == DRAIN;
    assign bus.dout_valid = run_q;
    assign bus.addr1      = addr1_q;
    assign bus.addr2      = addr2_q;
endmodule
